// File: rtl/present_pkg.sv
// ============================================================================
// Package     : present_pkg
// Description : Shared PRESENT-80 primitives: S-box tables, bit permutation
//               layers, forward/inverse key-schedule steps and the FSM state
//               type of the on-the-fly decryption core.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package present_pkg;

  localparam int KEY_W   = 80;
  localparam int BLOCK_W = 64;
  localparam int ROUNDS  = 31;

  // Round-counter value of the last key-schedule step / first inverse round.
  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY_FWD = 3'd1,
    WHITEN  = 3'd2,
    ROUND   = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) begin
      o[(i * 16) % 63] = s[i];
    end
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) begin
      o[i] = s[(i * 16) % 63];
    end
    o[63] = s[63];
    return o;
  endfunction

  // K(i) -> K(i+1): rotate left 61, S-box top nibble, XOR counter into [19:15].
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // K(i+1) -> K(i): exact reverse order of key_update.
  function automatic logic [KEY_W-1:0] inv_key_update(input logic [KEY_W-1:0] k,
                                                      input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = INV_SBOX[r[79:76]];
    r          = {r[60:0], r[79:61]};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/present_inv_round.sv
// ============================================================================
// Module      : present_inv_round
// Description : Combinational PRESENT-80 inverse round. Steps the key
//               schedule back one position and applies inverse permutation,
//               inverse S-box layer and the recovered round key.
// Ports       : state_i [63:0] - cipher state entering the round
//               key_i   [79:0] - key register holding K(rc+1)
//               rc_i    [4:0]  - round counter of this round
//               state_o [63:0] - cipher state after the round
//               kp_o    [79:0] - recovered key register K(rc)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_inv_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [4:0]         rc_i,
  output logic [BLOCK_W-1:0] state_o,
  output logic [KEY_W-1:0]   kp_o
);

  logic [BLOCK_W-1:0] w_pinv;
  logic [BLOCK_W-1:0] w_sinv;

  assign kp_o   = inv_key_update(key_i, rc_i);
  assign w_pinv = inv_p_layer(state_i);

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    assign w_sinv[4*g +: 4] = INV_SBOX[w_pinv[4*g +: 4]];
  end

  // The round key is the top 64 bits of the recovered key register.
  assign state_o = w_sinv ^ kp_o[79:16];

endmodule

`default_nettype wire

// File: rtl/present_dec_otf.sv
// ============================================================================
// Module      : present_dec_otf
// Description : PRESENT-80 decryption core with on-the-fly round keys. Walks
//               the key schedule forward to K32, whitens, then runs 31 inverse
//               rounds while stepping the schedule backwards. Optionally
//               caches K32 with its master key to skip expansion on reuse.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               start      - operation request (accepted in IDLE/DONE)
//               key [79:0] - master key, sampled with start
//               block_i    - ciphertext, sampled with start
//               busy       - operation in progress
//               block_o    - plaintext, held until next result
//               end_signal - result valid (DONE state)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_dec_otf
  import present_pkg::*;
#(
  parameter bit CACHE_KEY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] block_i,
  output logic               busy,
  output logic [BLOCK_W-1:0] block_o,
  output logic               end_signal
);

  state_e             fsm_q;
  logic [BLOCK_W-1:0] data_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   master_q;
  logic [4:0]         rc_q;
  logic [KEY_W-1:0]   cache_k32_q;
  logic [KEY_W-1:0]   cache_master_q;
  logic               cache_valid_q;
  logic               busy_q;
  logic [BLOCK_W-1:0] block_q;
  logic               end_q;

  logic [BLOCK_W-1:0] state_d;
  logic [KEY_W-1:0]   key_d;
  logic               w_cache_hit;

  present_inv_round u_inv_round (
    .state_i (data_q),
    .key_i   (key_q),
    .rc_i    (rc_q),
    .state_o (state_d),
    .kp_o    (key_d)
  );

  assign w_cache_hit = CACHE_KEY && cache_valid_q && (key == cache_master_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q          <= IDLE;
      data_q         <= '0;
      key_q          <= '0;
      master_q       <= '0;
      rc_q           <= '0;
      cache_k32_q    <= '0;
      cache_master_q <= '0;
      cache_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      block_q        <= '0;
      end_q          <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE, DONE: begin
          if (start) begin
            data_q   <= block_i;
            master_q <= key;
            end_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (w_cache_hit) begin
              key_q <= cache_k32_q;
              fsm_q <= WHITEN;
            end else begin
              key_q <= key;
              rc_q  <= 5'd1;
              fsm_q <= KEY_FWD;
            end
          end
        end

        KEY_FWD: begin
          key_q <= key_update(key_q, rc_q);
          if (rc_q == RC_LAST) begin
            fsm_q <= WHITEN;
          end else begin
            rc_q <= rc_q + 5'd1;
          end
        end

        WHITEN: begin
          // key_q holds K32 here whether expanded or taken from the cache.
          data_q <= data_q ^ key_q[79:16];
          if (CACHE_KEY) begin
            cache_k32_q    <= key_q;
            cache_master_q <= master_q;
            cache_valid_q  <= 1'b1;
          end
          rc_q  <= RC_LAST;
          fsm_q <= ROUND;
        end

        ROUND: begin
          data_q <= state_d;
          key_q  <= key_d;
          if (rc_q == 5'd1) begin
            block_q <= state_d;
            end_q   <= 1'b1;
            busy_q  <= 1'b0;
            fsm_q   <= DONE;
          end else begin
            rc_q <= rc_q - 5'd1;
          end
        end

        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign block_o    = block_q;
  assign end_signal = end_q;

endmodule

`default_nettype wire

// File: tb/tb_present_dec_otf.sv
// ============================================================================
// Module      : tb_present_dec_otf
// Description : Self-checking bench for present_dec_otf. Expected plaintext
//               and latency are queued at start and compared at end_signal.
//               A second instance without key caching shares the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_present_dec_otf;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sel;
  logic [79:0] key;
  logic [63:0] block_i;

  logic        busy_c, end_c, busy_n, end_n;
  logic [63:0] blk_c, blk_n;
  logic        start_c, start_n;

  logic        cur_busy, cur_end;
  logic [63:0] cur_blk;

  typedef struct {
    logic [63:0] pt;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_err;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] KF = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] PF = {64{1'b1}};

  assign start_c  = start & ~sel;
  assign start_n  = start & sel;
  assign cur_busy = sel ? busy_n : busy_c;
  assign cur_end  = sel ? end_n  : end_c;
  assign cur_blk  = sel ? blk_n  : blk_c;

  present_dec_otf #(.CACHE_KEY(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_c),
    .key        (key),
    .block_i    (block_i),
    .busy       (busy_c),
    .block_o    (blk_c),
    .end_signal (end_c)
  );

  present_dec_otf #(.CACHE_KEY(1'b0)) dut_nc (
    .clk        (clk),
    .rst        (rst),
    .start      (start_n),
    .key        (key),
    .block_i    (block_i),
    .busy       (busy_n),
    .block_o    (blk_n),
    .end_signal (end_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[79:0];
  endfunction

  // Start one operation on the selected instance and follow it to completion
  // (or to an injected reset at cycle abort_at when abort_at > 0).
  task automatic run_op(input string name, input logic [79:0] k, input logic [63:0] b,
                        input logic [63:0] exp_pt, input int exp_lat,
                        input bit glitch, input int abort_at);
    exp_t        e;
    int          cycles;
    bit          held_bad;
    bit          aborted;
    logic [63:0] prev;

    @(negedge clk);
    prev    = cur_blk;
    key     = k;
    block_i = b;
    start   = 1'b1;
    e.pt    = exp_pt;
    e.lat   = exp_lat;
    sb.push_back(e);

    @(posedge clk);
    #1;
    start   = 1'b0;
    key     = rnd80();
    block_i = {$urandom, $urandom};
    check_eq({name, ":busy_acc"}, 64'(cur_busy), 64'd1);
    check_eq({name, ":end_drop"}, 64'(cur_end), 64'd0);

    cycles   = 0;
    held_bad = 1'b0;
    aborted  = 1'b0;
    while (cur_end !== 1'b1 && cycles < 100 && !aborted) begin
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      if (glitch && (cycles == 5 || cycles == 20 || cycles == 50)) begin
        start   = 1'b1;
        key     = rnd80();
        block_i = {$urandom, $urandom};
      end
      if (cur_end !== 1'b1 && cur_blk !== prev) held_bad = 1'b1;
      if (cycles == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        aborted = 1'b1;
      end
    end

    check_eq({name, ":sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) e = sb.pop_front();

    if (aborted) begin
      check_eq({name, ":rst_blk"},  cur_blk, 64'd0);
      check_eq({name, ":rst_end"},  64'(cur_end), 64'd0);
      check_eq({name, ":rst_busy"}, 64'(cur_busy), 64'd0);
    end else begin
      check_eq({name, ":end"},   64'(cur_end), 64'd1);
      check_eq({name, ":block"}, cur_blk, e.pt);
      check_eq({name, ":lat"},   64'(cycles), 64'(e.lat));
      check_eq({name, ":busy"},  64'(cur_busy), 64'd0);
      check_eq({name, ":hold"},  64'(held_bad), 64'd0);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    sel     = 1'b0;
    start   = 1'b0;
    key     = '0;
    block_i = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset:blk",  blk_c, 64'd0);
    check_eq("reset:end",  64'(end_c), 64'd0);
    check_eq("reset:busy", 64'(busy_c), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("k0_full",   K0, 64'h5579C1387B228445, P0, 63, 1'b0, 0);
    run_op("kf_miss",   KF, 64'hE72C46C0F5945049, P0, 63, 1'b0, 0);
    run_op("kf_hit",    KF, 64'h3333DCD3213210D2, PF, 32, 1'b0, 0);
    run_op("k0_after",  K0, 64'hA112FFC72F68417B, PF, 63, 1'b0, 0);

    sel = 1'b1;
    run_op("nc_first",  K0, 64'hA112FFC72F68417B, PF, 63, 1'b0, 0);
    run_op("nc_repeat", K0, 64'hA112FFC72F68417B, PF, 63, 1'b0, 0);
    sel = 1'b0;

    // Cache holds K0 here, so KF forces a full expansion during the glitches.
    run_op("glitch",    KF, 64'hE72C46C0F5945049, P0, 63, 1'b1, 0);
    // K0 reaches the cache at WHITEN, then the reset at cycle 40 invalidates it.
    run_op("abort",     K0, 64'h5579C1387B228445, P0, 63, 1'b0, 40);
    run_op("post_rst",  K0, 64'h5579C1387B228445, P0, 63, 1'b0, 0);
    run_op("post_hit",  K0, 64'hA112FFC72F68417B, PF, 32, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
